// File: rtl/des_sbox_pkg.sv
// Shared types, widths and the DES S-box contents for the substitution engine.
package des_sbox_pkg;

    localparam int unsigned NUM_BOXES = 8;
    localparam int unsigned IN_W      = 48;
    localparam int unsigned OUT_W     = 32;
    localparam int unsigned BOX_IN_W  = 6;
    localparam int unsigned BOX_OUT_W = 4;
    localparam int unsigned IDX_W     = 3;
    localparam int unsigned ROWS      = 4;
    localparam int unsigned COLS      = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Slot NUM_BOXES-1 holds S1, slot 0 holds S8, matching the bus bit order.
    typedef logic [NUM_BOXES-1:0][BOX_IN_W-1:0]  box_in_vec_t;
    typedef logic [NUM_BOXES-1:0][BOX_OUT_W-1:0] box_out_vec_t;

    // Indexed [box][row]; each row word lists columns 0..15 from the MSB nibble down.
    localparam logic [COLS-1:0][BOX_OUT_W-1:0] SBOX_TABLE [NUM_BOXES][ROWS] = '{
        '{64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538, 64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D},
        '{64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5, 64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9},
        '{64'hA09E63F51DC7B428, 64'hD70934A6285ECBF1, 64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C},
        '{64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9, 64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E},
        '{64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986, 64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453},
        '{64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38, 64'h9EF528C3704A1DB6, 64'h432C95FABE17608D},
        '{64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86, 64'h14BDC37EAF680592, 64'h6BD814A7950FE23C},
        '{64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92, 64'h7B419CE206ADF358, 64'h21E74A8DFC90356B}
    };

    // Box number (0 = S1) to its slot in a packed box vector.
    function automatic logic [IDX_W-1:0] slot_of(input logic [IDX_W-1:0] box);
        return IDX_W'(NUM_BOXES - 1) - box;
    endfunction

endpackage

// File: rtl/des_sbox_lut.sv
// Single DES S-box lookup: box select plus 6-bit input to 4-bit nibble, purely combinational.
module des_sbox_lut
    import des_sbox_pkg::*;
(
    input  logic [IDX_W-1:0]     box,
    input  logic [BOX_IN_W-1:0]  din,
    output logic [BOX_OUT_W-1:0] nibble_c
);

    logic [1:0] row;
    logic [3:0] col;

    // Outer bits pick the row, inner four bits pick the column.
    always_comb begin
        row      = {din[5], din[0]};
        col      = din[4:1];
        nibble_c = SBOX_TABLE[box][row][4'(COLS - 1) - col];
    end

endmodule

// File: rtl/des_sbox_engine.sv
// Iterative DES S-box stage: LANES boxes per clock, valid/ready on both sides.
// Optional SBOX_XFER_CNT_EN adds a 16-bit wrapping count of output handshakes.
module des_sbox_engine
    import des_sbox_pkg::*;
#(
    parameter int unsigned LANES = 2
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
`ifdef SBOX_XFER_CNT_EN
    output logic [15:0]      xfer_count,
`endif
    output logic             busy
);

    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8)) begin : g_bad_lanes
        $error("des_sbox_engine: LANES must be 1, 2, 4 or 8");
    end

    state_t       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    box_in_vec_t  data_q, data_d;
    box_out_vec_t res_q, res_d;
    logic         out_valid_q;
    logic         last_step;

    logic [IDX_W-1:0]     lane_box [LANES];
    logic [BOX_OUT_W-1:0] lane_nib [LANES];

    // One LUT per lane, each looking at consecutive boxes from the current index.
    for (genvar g = 0; g < int'(LANES); g++) begin : g_lane
        assign lane_box[g] = idx_q + IDX_W'(g);
        des_sbox_lut u_lut (
            .box      (lane_box[g]),
            .din      (data_q[slot_of(lane_box[g])]),
            .nibble_c (lane_nib[g])
        );
    end

    assign last_step = (({1'b0, idx_q} + 4'(LANES)) == 4'(NUM_BOXES));

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        data_d  = data_q;
        res_d   = res_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    data_d  = in_data;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                for (int unsigned g = 0; g < LANES; g++) begin
                    res_d[slot_of(lane_box[g])] = lane_nib[g];
                end
                idx_d = idx_q + IDX_W'(LANES);
                if (last_step) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                // A completing handshake may capture the next block in the same cycle.
                if (out_ready) begin
                    if (in_valid) begin
                        data_d  = in_data;
                        idx_d   = '0;
                        state_d = RUN;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            data_q      <= '0;
            res_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            data_q      <= data_d;
            res_q       <= res_d;
            out_valid_q <= (state_d == DONE);
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = res_q;
    assign busy      = (state_q == RUN) || (state_q == DONE);
    assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);

`ifdef SBOX_XFER_CNT_EN
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            xfer_count <= '0;
        end else if (out_valid_q && out_ready) begin
            xfer_count <= xfer_count + 16'd1;
        end
    end
`endif

endmodule
